// File: rtl/adc_spi_sampler.sv
// MCP3202 SPI sampler: each sample_tick runs a channel 0 + channel 1 conversion
// pair and presents the results as signed 16-bit left/right audio words.
module adc_spi_sampler #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_tick,
  input  logic        adc_miso,
  output logic        adc_clk,
  output logic        adc_cs,
  output logic        adc_mosi,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  // One counter serves both the SCLK half-period and the 2*CLK_DIV inter-frame gap.
  localparam int            CW        = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [4:0]    LAST_BIT  = 5'd16;
  localparam logic [4:0]    FIRST_CAP = 5'd5;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP,
    DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_bit;
  logic          r_ch;
  logic [11:0]   r_shift;
  logic [11:0]   r_hold0;
  logic          r_adc_clk;
  logic          r_adc_cs;
  logic          r_adc_mosi;
  logic [15:0]   r_sample_l;
  logic [15:0]   r_sample_r;
  logic          r_sample_valid;
  logic          r_busy;
  logic          r_overrun;

  state_t        w_state;
  logic [CW-1:0] w_cnt;
  logic [4:0]    w_bit;
  logic          w_ch;
  logic [11:0]   w_shift;
  logic [11:0]   w_hold0;
  logic          w_adc_mosi;
  logic [15:0]   w_sample_l;
  logic [15:0]   w_sample_r;
  logic          w_adc_clk;
  logic          w_adc_cs;
  logic          w_sample_valid;
  logic          w_busy;
  logic          w_overrun;
  logic          w_last_half;
  logic          w_last_gap;

  // Command bits: start, single-ended, ODD = channel select, MSB-first, then zeros.
  function automatic logic cmd_bit(input logic [4:0] b, input logic ch);
    case (b)
      5'd0, 5'd1, 5'd3: cmd_bit = 1'b1;
      5'd2:             cmd_bit = ch;
      default:          cmd_bit = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] to_audio(input logic [11:0] d);
    to_audio = {~d[11], d[10:0], 4'b0000};
  endfunction

  assign w_last_half = (r_cnt == HALF_LAST);
  assign w_last_gap  = (r_cnt == GAP_LAST);

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_bit      = r_bit;
    w_ch       = r_ch;
    w_shift    = r_shift;
    w_hold0    = r_hold0;
    w_adc_mosi = r_adc_mosi;
    w_sample_l = r_sample_l;
    w_sample_r = r_sample_r;

    unique case (r_state)
      IDLE: begin
        if (sample_tick) begin
          w_state    = SETUP;
          w_ch       = 1'b0;
          w_cnt      = '0;
          w_shift    = '0;
          w_adc_mosi = 1'b1;
        end
      end
      SETUP: begin
        if (w_last_half) begin
          w_state = SHIFT_HI;
          w_bit   = '0;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (w_last_half) begin
          w_state    = SHIFT_LO;
          w_cnt      = '0;
          w_adc_mosi = cmd_bit(r_bit + 5'd1, r_ch);
          if (r_bit >= FIRST_CAP) begin
            w_shift = {r_shift[10:0], adc_miso};
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (w_last_half) begin
          w_cnt = '0;
          if (r_bit == LAST_BIT) begin
            // Channel 1 skips the gap so a pair takes exactly 72*CLK_DIV+1 cycles.
            if (!r_ch) begin
              w_state = GAP;
              w_hold0 = r_shift;
            end else begin
              w_state    = DONE;
              w_sample_l = to_audio(r_hold0);
              w_sample_r = to_audio(r_shift);
            end
          end else begin
            w_state = SHIFT_HI;
            w_bit   = r_bit + 5'd1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      GAP: begin
        if (w_last_gap) begin
          w_state    = SETUP;
          w_ch       = 1'b1;
          w_cnt      = '0;
          w_shift    = '0;
          w_adc_mosi = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase

    w_adc_cs       = !(w_state inside {SETUP, SHIFT_HI, SHIFT_LO});
    w_adc_clk      = (w_state == SHIFT_HI);
    w_busy         = !(w_state inside {IDLE, DONE});
    w_sample_valid = (w_state == DONE);
    w_overrun      = sample_tick && (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_bit          <= '0;
      r_ch           <= 1'b0;
      r_shift        <= '0;
      r_hold0        <= '0;
      r_adc_clk      <= 1'b0;
      r_adc_cs       <= 1'b1;
      r_adc_mosi     <= 1'b0;
      r_sample_l     <= '0;
      r_sample_r     <= '0;
      r_sample_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_cnt          <= w_cnt;
      r_bit          <= w_bit;
      r_ch           <= w_ch;
      r_shift        <= w_shift;
      r_hold0        <= w_hold0;
      r_adc_clk      <= w_adc_clk;
      r_adc_cs       <= w_adc_cs;
      r_adc_mosi     <= w_adc_mosi;
      r_sample_l     <= w_sample_l;
      r_sample_r     <= w_sample_r;
      r_sample_valid <= w_sample_valid;
      r_busy         <= w_busy;
      r_overrun      <= w_overrun;
    end
  end

  assign adc_clk      = r_adc_clk;
  assign adc_cs       = r_adc_cs;
  assign adc_mosi     = r_adc_mosi;
  assign sample_l     = r_sample_l;
  assign sample_r     = r_sample_r;
  assign sample_valid = r_sample_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: a behavioural MCP3202 serves one CLK_DIV=4 and one
// CLK_DIV=1 instance; expected samples go through a queue-based scoreboard.
module tb_adc_spi_sampler;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          t;
  } exp_t;

  typedef struct {
    logic [16:0] mosi;
    int          rises;
    int          lowLen;
    logic [34:0] sclkPat;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        resetN;
  logic        sampleTick;
  logic        adcMiso = 1'b0;
  logic        adcClk, adcCs, adcMosi, sampleValid, busy, overrun;
  logic [15:0] sampleL, sampleR;

  logic        tick1;
  logic        adcMiso1 = 1'b0;
  logic        adcClk1, adcCs1, adcMosi1, sampleValid1, busy1, overrun1;
  logic [15:0] sampleL1, sampleR1;

  int errors = 0;
  int checks = 0;

  exp_t sb4[$];
  exp_t sb1[$];

  adc_spi_sampler #(.CLK_DIV(4)) dut (
    .clk(clk), .reset_n(resetN), .sample_tick(sampleTick), .adc_miso(adcMiso),
    .adc_clk(adcClk), .adc_cs(adcCs), .adc_mosi(adcMosi),
    .sample_l(sampleL), .sample_r(sampleR), .sample_valid(sampleValid),
    .busy(busy), .overrun(overrun)
  );

  adc_spi_sampler #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(resetN), .sample_tick(tick1), .adc_miso(adcMiso1),
    .adc_clk(adcClk1), .adc_cs(adcCs1), .adc_mosi(adcMosi1),
    .sample_l(sampleL1), .sample_r(sampleR1), .sample_valid(sampleValid1),
    .busy(busy1), .overrun(overrun1)
  );

  // ADC output for SCLK period b: null bit driven 1, bits 5..16 carry the code MSB first.
  function automatic logic adcBit(input int b, input logic ch, input logic [11:0] d0,
                                  input logic [11:0] d1);
    logic [11:0] d;
    d = ch ? d1 : d0;
    if (b == 4) return 1'b1;
    if (b >= 5 && b <= 16) return d[16 - b];
    return 1'b0;
  endfunction

  // ADC model and bus monitor for the CLK_DIV=4 instance.
  logic [11:0] data4 [2];
  logic [16:0] mBits4 = '0;
  int mRises4 = 0, mLow4 = 0, gapCnt4 = 0, lastGap4 = 0;
  logic prevCs4 = 1'b1, prevClk4 = 1'b0;
  frame_t fr4[$];
  int ov4[$];

  always @(negedge clk) begin
    if (!adcCs && prevCs4) begin
      lastGap4 = gapCnt4;
      gapCnt4  = 0;
      mBits4   = '0;
      mRises4  = 0;
      mLow4    = 0;
    end
    if (adcCs) gapCnt4++;
    if (!adcCs) begin
      if (adcClk && !prevClk4) begin
        if (mRises4 < 17) mBits4[mRises4] = adcMosi;
        adcMiso = adcBit(mRises4, mBits4[2], data4[0], data4[1]);
        mRises4++;
      end
      mLow4++;
    end
    if (adcCs && !prevCs4) fr4.push_back('{mBits4, mRises4, mLow4, 35'd0});
    if (overrun) ov4.push_back(cyc);
    prevCs4  = adcCs;
    prevClk4 = adcClk;
  end

  // ADC model and bus monitor for the CLK_DIV=1 instance, also recording the SCLK waveform.
  logic [11:0] data1 [2];
  logic [16:0] mBits1 = '0;
  logic [34:0] mPat1 = '0;
  int mRises1 = 0, mLow1 = 0, gapCnt1 = 0, lastGap1 = 0;
  logic prevCs1 = 1'b1, prevClk1 = 1'b0;
  frame_t fr1[$];

  always @(negedge clk) begin
    if (!adcCs1 && prevCs1) begin
      lastGap1 = gapCnt1;
      gapCnt1  = 0;
      mBits1   = '0;
      mPat1    = '0;
      mRises1  = 0;
      mLow1    = 0;
    end
    if (adcCs1) gapCnt1++;
    if (!adcCs1) begin
      if (mLow1 < 35) mPat1[mLow1] = adcClk1;
      if (adcClk1 && !prevClk1) begin
        if (mRises1 < 17) mBits1[mRises1] = adcMosi1;
        adcMiso1 = adcBit(mRises1, mBits1[2], data1[0], data1[1]);
        mRises1++;
      end
      mLow1++;
    end
    if (adcCs1 && !prevCs1) fr1.push_back('{mBits1, mRises1, mLow1, mPat1});
    prevCs1  = adcCs1;
    prevClk1 = adcClk1;
  end

  task automatic pulseTick4(output int t);
    @(negedge clk);
    sampleTick = 1'b1;
    t = cyc;
    @(negedge clk);
    sampleTick = 1'b0;
  endtask

  // Waits for the next sample_valid and scores it against the front of the queue.
  task automatic waitForSample4(input int budget);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sampleValid && n < budget);
    checks++;
    if (sampleValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL valid_timeout: sample_valid=%b after %0d cycles, required 1", sampleValid, n);
      return;
    end
    checks++;
    if (sb4.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_valid: sample_valid at cycle %0d, scoreboard empty", cyc);
      return;
    end
    e = sb4.pop_front();
    checks++;
    if (cyc !== e.t) begin
      errors++;
      $display("[TB] FAIL valid_cycle: got cycle %0d, required %0d", cyc, e.t);
    end
    checks++;
    if (sampleL !== e.l) begin
      errors++;
      $display("[TB] FAIL sample_l: got %h, required %h", sampleL, e.l);
    end
    checks++;
    if (sampleR !== e.r) begin
      errors++;
      $display("[TB] FAIL sample_r: got %h, required %h", sampleR, e.r);
    end
    checks++;
    if ({busy, adcCs} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL done_busy_cs: got busy/cs=%b, required 01", {busy, adcCs});
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({adcCs, adcClk, adcMosi, sampleValid, busy, overrun} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_ctl: got cs/clk/mosi/valid/busy/ovr=%b, required 100000",
               {adcCs, adcClk, adcMosi, sampleValid, busy, overrun});
    end
    checks++;
    if ({sampleL, sampleR} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_samples: got %h, required 00000000", {sampleL, sampleR});
    end
    checks++;
    if ({adcCs1, adcClk1, busy1} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_div1: got cs/clk/busy=%b, required 100", {adcCs1, adcClk1, busy1});
    end
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({adcCs, busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got cs/busy=%b, required 10", {adcCs, busy});
    end
  endtask

  task automatic test_fullscale();
    int t;
    int f0;
    int o0;
    f0 = fr4.size();
    o0 = ov4.size();
    data4[0] = 12'hFFF;
    data4[1] = 12'h000;
    pulseTick4(t);
    sb4.push_back('{16'h7FF0, 16'h8000, t + 289});
    waitForSample4(400);
    repeat (2) @(negedge clk);
    checks++;
    if (fr4.size() !== f0 + 2) begin
      errors++;
      $display("[TB] FAIL frame_count: got %0d frames, required %0d", fr4.size() - f0, 2);
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [16:0] wantMosi;
        wantMosi = (i == 0) ? 17'h0000B : 17'h0000F;
        checks++;
        if (fr4[f0 + i].mosi !== wantMosi) begin
          errors++;
          $display("[TB] FAIL mosi_frame%0d: got %h, required %h", i, fr4[f0 + i].mosi, wantMosi);
        end
        checks++;
        if (fr4[f0 + i].rises !== 17) begin
          errors++;
          $display("[TB] FAIL sclk_rises%0d: got %0d, required 17", i, fr4[f0 + i].rises);
        end
        checks++;
        if (fr4[f0 + i].lowLen !== 140) begin
          errors++;
          $display("[TB] FAIL cs_low_len%0d: got %0d, required 140", i, fr4[f0 + i].lowLen);
        end
      end
    end
    checks++;
    if (lastGap4 !== 8) begin
      errors++;
      $display("[TB] FAIL cs_gap: got %0d cycles, required 8", lastGap4);
    end
    checks++;
    if (ov4.size() !== o0) begin
      errors++;
      $display("[TB] FAIL no_overrun: got %0d pulses, required 0", ov4.size() - o0);
    end
  endtask

  task automatic test_midscale();
    int t;
    data4[0] = 12'h800;
    data4[1] = 12'hA5A;
    pulseTick4(t);
    sb4.push_back('{16'h0000, 16'h25A0, t + 289});
    waitForSample4(400);
  endtask

  task automatic test_overrun();
    int t;
    int o0;
    o0 = ov4.size();
    data4[0] = 12'h123;
    data4[1] = 12'h456;
    pulseTick4(t);
    sb4.push_back('{16'h9230, 16'hC560, t + 289});
    fork
      begin
        while (cyc < t + 292) begin
          @(negedge clk);
          sampleTick = (cyc == t + 50) || (cyc == t + 289) || (cyc == t + 290);
          if (cyc == t + 290) begin
            sb4.push_back('{16'h9230, 16'hC560, t + 290 + 289});
            checks++;
            if (adcCs !== 1'b1) begin
              errors++;
              $display("[TB] FAIL cs_after_done: got %b, required 1", adcCs);
            end
          end
          if (cyc == t + 291) begin
            checks++;
            if (adcCs !== 1'b0) begin
              errors++;
              $display("[TB] FAIL cs_restart: got %b, required 0", adcCs);
            end
          end
        end
        sampleTick = 1'b0;
      end
      waitForSample4(400);
    join
    waitForSample4(400);
    checks++;
    if (ov4.size() !== o0 + 2) begin
      errors++;
      $display("[TB] FAIL overrun_count: got %0d pulses, required 2", ov4.size() - o0);
    end else begin
      checks++;
      if (ov4[o0] !== t + 51 || ov4[o0 + 1] !== t + 290) begin
        errors++;
        $display("[TB] FAIL overrun_cycles: got T+%0d,T+%0d, required T+51,T+290",
                 ov4[o0] - t, ov4[o0 + 1] - t);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int   t;
    logic sawValid;
    data4[0] = 12'hFFF;
    data4[1] = 12'h800;
    pulseTick4(t);
    while (cyc < t + 100) @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++;
    if ({adcCs, adcClk, busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL async_reset_ctl: got cs/clk/busy=%b, required 100", {adcCs, adcClk, busy});
    end
    checks++;
    if ({sampleL, sampleR} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_samples: got %h, required 00000000", {sampleL, sampleR});
    end
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    sawValid = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (sampleValid) sawValid = 1'b1;
    end
    checks++;
    if (sawValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_valid_after_reset: got valid=%b, required 0", sawValid);
    end
    pulseTick4(t);
    sb4.push_back('{16'h7FF0, 16'h0000, t + 289});
    waitForSample4(400);
  endtask

  task automatic test_clkdiv1();
    int   t;
    int   n;
    int   f0;
    exp_t e;
    f0 = fr1.size();
    data1[0] = 12'hA5A;
    data1[1] = 12'h5A5;
    @(negedge clk);
    tick1 = 1'b1;
    t = cyc;
    sb1.push_back('{16'h25A0, 16'hDA50, t + 73});
    @(negedge clk);
    tick1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sampleValid1 && n < 200);
    checks++;
    if (sampleValid1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div1_timeout: sample_valid=%b after %0d cycles, required 1", sampleValid1, n);
    end else begin
      e = sb1.pop_front();
      checks++;
      if (cyc !== e.t) begin
        errors++;
        $display("[TB] FAIL div1_cycle: got cycle %0d, required %0d", cyc, e.t);
      end
      checks++;
      if ({sampleL1, sampleR1} !== {e.l, e.r}) begin
        errors++;
        $display("[TB] FAIL div1_samples: got %h, required %h", {sampleL1, sampleR1}, {e.l, e.r});
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (fr1.size() !== f0 + 2) begin
      errors++;
      $display("[TB] FAIL div1_frames: got %0d frames, required 2", fr1.size() - f0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [16:0] wantMosi;
        wantMosi = (i == 0) ? 17'h0000B : 17'h0000F;
        checks++;
        if (fr1[f0 + i].mosi !== wantMosi) begin
          errors++;
          $display("[TB] FAIL div1_mosi%0d: got %h, required %h", i, fr1[f0 + i].mosi, wantMosi);
        end
        checks++;
        if (fr1[f0 + i].lowLen !== 35 || fr1[f0 + i].rises !== 17) begin
          errors++;
          $display("[TB] FAIL div1_len%0d: got low=%0d rises=%0d, required 35/17",
                   i, fr1[f0 + i].lowLen, fr1[f0 + i].rises);
        end
        checks++;
        if (fr1[f0 + i].sclkPat !== 35'h2AAAAAAAA) begin
          errors++;
          $display("[TB] FAIL div1_sclk%0d: got %h, required 2aaaaaaaa", i, fr1[f0 + i].sclkPat);
        end
      end
    end
    checks++;
    if (lastGap1 !== 2) begin
      errors++;
      $display("[TB] FAIL div1_gap: got %0d cycles, required 2", lastGap1);
    end
  endtask

  initial begin
    resetN     = 1'b0;
    sampleTick = 1'b0;
    tick1      = 1'b0;
    data4[0]   = '0;
    data4[1]   = '0;
    data1[0]   = '0;
    data1[1]   = '0;
    test_reset();
    test_fullscale();
    test_midscale();
    test_overrun();
    test_reset_midframe();
    test_clkdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
